// File: rtl/serial_ripple_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_arith_pkg;

  localparam int SA_DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_ripple_adder_if.sv
// Start/done operand-and-result bundle for the bit-serial adder.
interface serial_ripple_adder_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  // Requester side: issues operands, observes results.
  modport master (
    output start, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  // Adder side: accepts operands, produces results.
  modport slave (
    input  start, a, b, cin,
    output sum, cout, ovf, busy, done
  );

endinterface

// File: rtl/serial_ripple_adder_fa.sv
// Single full-adder cell reused once per bit time by the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_ripple_adder.sv
// Bit-serial A + B + cin: one full-adder cell plus a carry flop, LSB first.
// Result, carry-out and signed overflow are registered and held until the
// next operation completes; done pulses for the single DONE cycle.
module serial_ripple_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_ripple_adder_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        state;
  sa_state_t        state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic             cell_s;
  logic             cell_c;
  logic             last_bit;

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (cell_s),
    .cout (cell_c)
  );

  // The MSB is being added this cycle; carry holds the carry into the MSB.
  assign last_bit = (state == RUN) && (cnt == LAST_CNT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, accumulator, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {cell_s, acc[WIDTH-1:1]};
          carry <= cell_c;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: written only as the MSB completes, so partial sums stay hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_bit;
      if (last_bit) begin
        sum_q  <= {cell_s, acc[WIDTH-1:1]};
        cout_q <= cell_c;
        ovf_q  <= carry ^ cell_c;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);

endmodule
